// File: rtl/qr_pkg.sv
// -----------------------------------------------------------------------------
// qr_pkg
// Shared definitions for the finder-pattern scanner.
//   - Widths derived from the default 480x480 frame (COORD_W, ADDR_W, RUN_W).
//   - run_len_t: run-length counter type at the default frame size.
//   - scan_state_t: scanner FSM states.
//   - Ratio constants for the 1:1:3:1:1 finder test, scaled by 14 so the
//     comparison stays in integer arithmetic.
// -----------------------------------------------------------------------------
package qr_pkg;

    localparam int unsigned DEFAULT_SIZE = 480;
    localparam int unsigned COORD_W      = $clog2(DEFAULT_SIZE);
    localparam int unsigned ADDR_W       = $clog2(DEFAULT_SIZE * DEFAULT_SIZE);
    localparam int unsigned RUN_W        = $clog2(DEFAULT_SIZE + 1);

    typedef logic [RUN_W-1:0] run_len_t;

    // Sum of five runs and all ratio products.
    localparam int unsigned TOTAL_W = 12;
    localparam int unsigned PROD_W  = 16;

    // Each run is compared as 14*r against multiples of the total T.
    localparam logic [PROD_W-1:0] RATIO_SCALE    = 16'd14;
    localparam logic [PROD_W-1:0] RATIO_SIDE_MAX = 16'd3;
    localparam logic [PROD_W-1:0] RATIO_CTR_MIN  = 16'd5;
    localparam logic [PROD_W-1:0] RATIO_CTR_MAX  = 16'd7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROW_SCAN  = 3'd1,
        ROW_DRAIN = 3'd2,
        COL_SCAN  = 3'd3,
        COL_DRAIN = 3'd4,
        DONE      = 3'd5
    } scan_state_t;

endpackage

// File: rtl/finder_ratio_check.sv
// -----------------------------------------------------------------------------
// finder_ratio_check
// Five-entry history of closed runs plus the 1:1:3:1:1 ratio comparator.
// Up to two runs can close in one cycle (a colour change on the last pixel of
// a line closes the previous run and the one-pixel final run), so the history
// accepts a "change" close followed by an "end of line" close.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   restart_i             first pixel of a line: history is discarded
//   close_i/_len_i/_dark_i  run closed by a colour change
//   end_i/_len_i/_dark_i    run closed by the end of the line
//   hit_o                 combinational pulse: a dark close completed a finder ratio
// -----------------------------------------------------------------------------
module finder_ratio_check
    import qr_pkg::*;
#(
    parameter int unsigned RUN_W_P = RUN_W,
    parameter int unsigned MIN_T   = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               restart_i,
    input  logic               close_i,
    input  logic [RUN_W_P-1:0] close_len_i,
    input  logic               close_dark_i,
    input  logic               end_i,
    input  logic [RUN_W_P-1:0] end_len_i,
    input  logic               end_dark_i,
    output logic               hit_o
);

    typedef struct packed {
        logic               vld;
        logic               dark;
        logic [RUN_W_P-1:0] len;
    } run_t;

    // Entry 0 is the newest run (r5), entry 4 the oldest (r1).
    typedef run_t [4:0] hist_t;

    hist_t hist_q;
    hist_t hist_d;
    hist_t hist_base_s;
    hist_t hist_a_s;
    hist_t hist_b_s;

    // A light run arriving into an empty history is the leading light run
    // of the line and is dropped.
    function automatic hist_t push(input hist_t h, input logic [RUN_W_P-1:0] len,
                                   input logic dark);
        hist_t r;
        if (dark || h[0].vld) begin
            r[4:1] = h[3:0];
            r[0]   = '{vld: 1'b1, dark: dark, len: len};
        end else begin
            r = h;
        end
        return r;
    endfunction

    function automatic logic side_ok(input logic [RUN_W_P-1:0] len,
                                     input logic [TOTAL_W-1:0] t);
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] tt;
        p  = RATIO_SCALE * PROD_W'(len);
        tt = PROD_W'(t);
        return (p >= tt) && (p <= RATIO_SIDE_MAX * tt);
    endfunction

    function automatic logic centre_ok(input logic [RUN_W_P-1:0] len,
                                       input logic [TOTAL_W-1:0] t);
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] tt;
        p  = RATIO_SCALE * PROD_W'(len);
        tt = PROD_W'(t);
        return (p >= RATIO_CTR_MIN * tt) && (p <= RATIO_CTR_MAX * tt);
    endfunction

    function automatic logic ratio_ok(input hist_t h);
        logic               shape;
        logic [TOTAL_W-1:0] t;
        shape = h[0].vld && h[1].vld && h[2].vld && h[3].vld && h[4].vld &&
                h[0].dark && !h[1].dark && h[2].dark && !h[3].dark && h[4].dark;
        t = TOTAL_W'(h[0].len) + TOTAL_W'(h[1].len) + TOTAL_W'(h[2].len) +
            TOTAL_W'(h[3].len) + TOTAL_W'(h[4].len);
        return shape && (t >= TOTAL_W'(MIN_T)) &&
               side_ok(h[4].len, t) && side_ok(h[3].len, t) &&
               centre_ok(h[2].len, t) &&
               side_ok(h[1].len, t) && side_ok(h[0].len, t);
    endfunction

    // History update for this cycle and hit evaluation on each dark close.
    always_comb begin
        hist_base_s = restart_i ? '0 : hist_q;
        hist_a_s    = close_i ? push(hist_base_s, close_len_i, close_dark_i) : hist_base_s;
        hist_b_s    = end_i ? push(hist_a_s, end_len_i, end_dark_i) : hist_a_s;
        hist_d      = hist_b_s;
        hit_o       = (close_i && close_dark_i && ratio_ok(hist_a_s)) ||
                      (end_i && end_dark_i && ratio_ok(hist_b_s));
    end

    // History register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/finder_scan.sv
// -----------------------------------------------------------------------------
// finder_scan
// Scans a binarized SIZE x SIZE frame buffer row-major then column-major and
// flags every row/column that contains a 1:1:3:1:1 finder ratio.
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   start_scan       start request, sampled only in IDLE
//   pixel_addr       frame-buffer read address row*SIZE+col
//   pixel_data       pixel (1 = dark), READ_LATENCY cycles after pixel_addr
//   horz_patterns    bit r set when row r holds a finder ratio
//   vert_patterns    bit c set when column c holds a finder ratio
//   patterns_valid   one-cycle pulse, both vectors final
//   busy             high outside IDLE
//   horz_count, vert_count  set-bit counts of the vectors (only with the
//                    FINDER_SCAN_COUNT_EN macro defined)
// -----------------------------------------------------------------------------
module finder_scan
    import qr_pkg::*;
#(
    parameter int unsigned SIZE         = 480,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MIN_T        = 7
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_scan,
    output logic [$clog2(SIZE*SIZE)-1:0]  pixel_addr,
    input  logic                          pixel_data,
    output logic [SIZE-1:0]               horz_patterns,
    output logic [SIZE-1:0]               vert_patterns,
    output logic                          patterns_valid,
`ifdef FINDER_SCAN_COUNT_EN
    output logic [$clog2(SIZE+1)-1:0]     horz_count,
    output logic [$clog2(SIZE+1)-1:0]     vert_count,
`endif
    output logic                          busy
);

    localparam int unsigned A_W   = $clog2(SIZE * SIZE);
    localparam int unsigned C_W   = $clog2(SIZE);
    localparam int unsigned R_W   = $clog2(SIZE + 1);
    localparam int unsigned D_W   = $clog2(READ_LATENCY + 1);
    // Tag layout: {valid, vertical pass, first, last, line index}
    localparam int unsigned TAG_W = C_W + 4;

    scan_state_t state_q, state_d;
    logic [C_W-1:0]   row_q, row_d, col_q, col_d;
    logic [D_W-1:0]   drain_q, drain_d;
    logic [A_W-1:0]   addr_d;
    logic             busy_d, valid_d;
    logic             start_accept_s, scan_last_s, drain_last_s;
    logic [TAG_W-1:0] tag_issue_s;
    logic [TAG_W-1:0] tag_pipe_q [READ_LATENCY];
    logic             al_valid_s, al_vert_s, al_first_s, al_last_s;
    logic [C_W-1:0]   al_line_s;
    logic [R_W-1:0]   run_len_q, run_len_d;
    logic             run_dark_q, run_dark_d;
    logic             restart_s, close_s, end_s, hit_s;
    logic [R_W-1:0]   close_len_s, end_len_s;
    logic             close_dark_s, end_dark_s;
    logic [SIZE-1:0]  horz_d, vert_d;

    assign start_accept_s = (state_q == IDLE) && start_scan;
    assign scan_last_s    = (row_q == C_W'(SIZE - 1)) && (col_q == C_W'(SIZE - 1));
    assign drain_last_s   = (drain_q == D_W'(READ_LATENCY - 1));

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = start_scan   ? ROW_SCAN  : IDLE;
            ROW_SCAN:  state_d = scan_last_s  ? ROW_DRAIN : ROW_SCAN;
            ROW_DRAIN: state_d = drain_last_s ? COL_SCAN  : ROW_DRAIN;
            COL_SCAN:  state_d = scan_last_s  ? COL_DRAIN : COL_SCAN;
            COL_DRAIN: state_d = drain_last_s ? DONE      : COL_DRAIN;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state register.
    always_comb begin
        busy_d  = 1'b1;
        valid_d = 1'b0;
        case (state_d)
            IDLE:    busy_d  = 1'b0;
            DONE:    valid_d = 1'b1;
            default: busy_d  = 1'b1;
        endcase
    end

    // Scan counters, address and the tag issued with each address.
    // ROW_SCAN steps col fastest, COL_SCAN steps row fastest; both wrap to
    // (0,0) after the last pixel so the next pass starts clean.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        tag_issue_s = '0;
        case (state_q)
            IDLE: begin
                if (start_scan) begin
                    row_d = '0;
                    col_d = '0;
                end else begin
                    row_d = row_q;
                end
            end
            ROW_SCAN: begin
                tag_issue_s = {1'b1, 1'b0, (col_q == '0), (col_q == C_W'(SIZE - 1)), row_q};
                if (col_q == C_W'(SIZE - 1)) begin
                    col_d = '0;
                    row_d = (row_q == C_W'(SIZE - 1)) ? '0 : row_q + C_W'(1);
                end else begin
                    col_d = col_q + C_W'(1);
                end
            end
            COL_SCAN: begin
                tag_issue_s = {1'b1, 1'b1, (row_q == '0), (row_q == C_W'(SIZE - 1)), col_q};
                if (row_q == C_W'(SIZE - 1)) begin
                    row_d = '0;
                    col_d = (col_q == C_W'(SIZE - 1)) ? '0 : col_q + C_W'(1);
                end else begin
                    row_d = row_q + C_W'(1);
                end
            end
            default: begin
                row_d = row_q;
            end
        endcase
        if (((state_q == ROW_DRAIN) || (state_q == COL_DRAIN)) && !drain_last_s) begin
            drain_d = drain_q + D_W'(1);
        end else begin
            drain_d = '0;
        end
        addr_d = A_W'(row_d) * A_W'(SIZE) + A_W'(col_d);
    end

    // Counter, address and status registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_q          <= '0;
            col_q          <= '0;
            drain_q        <= '0;
            pixel_addr     <= '0;
            busy           <= 1'b0;
            patterns_valid <= 1'b0;
        end else begin
            row_q          <= row_d;
            col_q          <= col_d;
            drain_q        <= drain_d;
            pixel_addr     <= addr_d;
            busy           <= busy_d;
            patterns_valid <= valid_d;
        end
    end

    // Tag delay line: the last stage lines up with pixel_data.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            tag_pipe_q[0] <= tag_issue_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    assign al_valid_s = tag_pipe_q[READ_LATENCY-1][C_W+3];
    assign al_vert_s  = tag_pipe_q[READ_LATENCY-1][C_W+2];
    assign al_first_s = tag_pipe_q[READ_LATENCY-1][C_W+1];
    assign al_last_s  = tag_pipe_q[READ_LATENCY-1][C_W];
    assign al_line_s  = tag_pipe_q[READ_LATENCY-1][C_W-1:0];

    // Run tracker: extends the current run or closes it on a colour change;
    // the last pixel of a line additionally closes whatever run is open.
    always_comb begin
        run_len_d    = run_len_q;
        run_dark_d   = run_dark_q;
        restart_s    = 1'b0;
        close_s      = 1'b0;
        close_len_s  = run_len_q;
        close_dark_s = run_dark_q;
        end_s        = 1'b0;
        end_len_s    = run_len_q;
        end_dark_s   = run_dark_q;
        if (al_valid_s) begin
            restart_s = al_first_s;
            if (al_first_s) begin
                run_len_d  = R_W'(1);
                run_dark_d = pixel_data;
            end else if (pixel_data == run_dark_q) begin
                run_len_d = (run_len_q == R_W'(SIZE)) ? run_len_q : run_len_q + R_W'(1);
            end else begin
                close_s    = 1'b1;
                run_len_d  = R_W'(1);
                run_dark_d = pixel_data;
            end
            end_s      = al_last_s;
            end_len_s  = run_len_d;
            end_dark_s = run_dark_d;
        end else begin
            restart_s = 1'b0;
        end
    end

    // Run tracker registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            run_len_q  <= '0;
            run_dark_q <= 1'b0;
        end else begin
            run_len_q  <= run_len_d;
            run_dark_q <= run_dark_d;
        end
    end

    finder_ratio_check #(
        .RUN_W_P (R_W),
        .MIN_T   (MIN_T)
    ) u_ratio (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .restart_i    (restart_s),
        .close_i      (close_s),
        .close_len_i  (close_len_s),
        .close_dark_i (close_dark_s),
        .end_i        (end_s),
        .end_len_i    (end_len_s),
        .end_dark_i   (end_dark_s),
        .hit_o        (hit_s)
    );

    // Sticky hit vectors, cleared when a scan is accepted.
    always_comb begin
        horz_d = horz_patterns;
        vert_d = vert_patterns;
        if (start_accept_s) begin
            horz_d = '0;
            vert_d = '0;
        end else if (hit_s && al_vert_s) begin
            vert_d[al_line_s] = 1'b1;
        end else if (hit_s) begin
            horz_d[al_line_s] = 1'b1;
        end else begin
            horz_d = horz_patterns;
        end
    end

    // Hit vector registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            horz_patterns <= '0;
            vert_patterns <= '0;
        end else begin
            horz_patterns <= horz_d;
            vert_patterns <= vert_d;
        end
    end

`ifdef FINDER_SCAN_COUNT_EN
    // Counts step only when a hit sets a bit that was still clear, so they
    // stay equal to the popcount and are final together with the vectors.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            horz_count <= '0;
            vert_count <= '0;
        end else if (start_accept_s) begin
            horz_count <= '0;
            vert_count <= '0;
        end else if (hit_s && al_vert_s && !vert_patterns[al_line_s]) begin
            vert_count <= vert_count + R_W'(1);
        end else if (hit_s && !al_vert_s && !horz_patterns[al_line_s]) begin
            horz_count <= horz_count + R_W'(1);
        end else begin
            horz_count <= horz_count;
        end
    end
`endif

endmodule

// File: tb/tb_finder_scan.sv
// -----------------------------------------------------------------------------
// tb_finder_scan
// Table of frames with hand-derived expected hit vectors, applied to
// finder_scan (SIZE=64, READ_LATENCY=2) through a behavioural frame buffer,
// plus reset-abort and mid-scan-start sequences.
// -----------------------------------------------------------------------------
module tb_finder_scan;

    localparam int SIZE     = 64;
    localparam int RL       = 2;
    localparam int AW       = 12;
    localparam int DONE_CYC = 2 * SIZE * SIZE + 2 * RL + 1;
    localparam int NVEC     = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   addr;
    logic            pdata;
    logic [SIZE-1:0] horz;
    logic [SIZE-1:0] vert;
    logic            pv;
    logic            busy;
`ifdef FINDER_SCAN_COUNT_EN
    logic [6:0]      hcnt;
    logic [6:0]      vcnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural frame buffer with a two-cycle read latency.
    logic mem [SIZE*SIZE];
    logic rd0 = 1'b0;
    logic rd1 = 1'b0;
    always @(posedge clk) begin
        rd0 <= mem[addr];
        rd1 <= rd0;
    end
    assign pdata = rd1;

    finder_scan #(
        .SIZE         (SIZE),
        .READ_LATENCY (RL),
        .MIN_T        (7)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .start_scan     (start),
        .pixel_addr     (addr),
        .pixel_data     (pdata),
        .horz_patterns  (horz),
        .vert_patterns  (vert),
        .patterns_valid (pv),
`ifdef FINDER_SCAN_COUNT_EN
        .horz_count     (hcnt),
        .vert_count     (vcnt),
`endif
        .busy           (busy)
    );

    // kind: 0 blank, 1 runs along row 'line', 2 runs down column 'line',
    //       3 ringed square at 10..37, 4 runs broken across rows 7/8
    typedef struct {
        int          kind;
        int          line;
        int          start;
        int          r0, r1, r2, r3, r4;
        logic [63:0] exp_h;
        logic [63:0] exp_v;
    } vec_t;

    typedef struct {
        logic [63:0] h;
        logic [63:0] v;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic paint(input vec_t t);
        int lens[5];
        int pos;
        int d;
        for (int i = 0; i < SIZE * SIZE; i++) mem[i] = 1'b0;
        lens = '{t.r0, t.r1, t.r2, t.r3, t.r4};
        if (t.kind == 1 || t.kind == 2) begin
            pos = t.start;
            for (int k = 0; k < 5; k++) begin
                for (int j = 0; j < lens[k]; j++) begin
                    if (t.kind == 1) mem[t.line * SIZE + pos] = (k % 2 == 0);
                    else             mem[pos * SIZE + t.line] = (k % 2 == 0);
                    pos++;
                end
            end
        end else if (t.kind == 3) begin
            // ring depth d: 0..3 dark, 4..7 light, 8..13 dark centre
            for (int r = 10; r <= 37; r++) begin
                for (int c = 10; c <= 37; c++) begin
                    d = r - 10;
                    if (37 - r < d) d = 37 - r;
                    if (c - 10 < d) d = c - 10;
                    if (37 - c < d) d = 37 - c;
                    mem[r * SIZE + c] = (d < 4) || (d >= 8);
                end
            end
        end else if (t.kind == 4) begin
            mem[7 * SIZE + 59] = 1'b1;
            mem[7 * SIZE + 61] = 1'b1;
            mem[7 * SIZE + 62] = 1'b1;
            mem[7 * SIZE + 63] = 1'b1;
            mem[8 * SIZE + 1]  = 1'b1;
        end
    endtask

    task automatic run_scan(input exp_t e, input int mid_start, input string tag);
        int   cyc;
        int   busy_hi;
        bit   got;
        exp_t ex;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b1;
        cyc     = 0;
        busy_hi = 0;
        got     = 1'b0;
        while (!got && cyc < DONE_CYC + 500) begin
            @(negedge clk);
            cyc++;
            start = (cyc == mid_start);
            if (cyc == 1) check({tag, " cleared"}, {horz, vert} != 128'd0, 64'd0);
            if (busy && cyc <= DONE_CYC - 1) busy_hi++;
            if (pv) got = 1'b1;
        end
        start = 1'b0;
        ex = sb.pop_front();
        if (!got) begin
            check({tag, " valid seen"}, 64'd0, 64'd1);
        end else begin
            check({tag, " done cycle"}, cyc, ex.cyc);
            check({tag, " horz"}, horz, ex.h);
            check({tag, " vert"}, vert, ex.v);
            check({tag, " busy cycles"}, busy_hi, DONE_CYC - 1);
`ifdef FINDER_SCAN_COUNT_EN
            check({tag, " horz count"}, hcnt, $countones(ex.h));
            check({tag, " vert count"}, vcnt, $countones(ex.v));
`endif
            @(negedge clk);
            check({tag, " pulse/busy after"}, {pv, busy}, 64'd0);
            repeat (3) @(negedge clk);
            check({tag, " horz hold"}, horz, ex.h);
        end
    endtask

    initial begin : main
        exp_t e;
        int   pv_seen;
        int   cyc;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0};
        tbl[1] = '{1, 10, 20, 4, 4, 12, 4, 4, 64'd1 << 10, 64'd0};
        tbl[2] = '{1, 5, 20, 4, 4, 20, 4, 4, 64'd0, 64'd0};
        tbl[3] = '{1, 5, 57, 1, 1, 3, 1, 1, 64'd1 << 5, 64'd0};
        tbl[4] = '{2, 40, 57, 1, 1, 3, 1, 1, 64'd0, 64'd1 << 40};
        // Only lines through the ring centre (18..29) cross five runs; outer
        // lines see one solid run or dark/light/dark.
        tbl[5] = '{3, 0, 0, 0, 0, 0, 0, 0, 64'h0000_0000_3FFC_0000, 64'h0000_0000_3FFC_0000};
        tbl[6] = '{4, 0, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0};

        rst   = 1'b1;
        start = 1'b0;
        paint(tbl[0]);
        repeat (3) @(negedge clk);
        check("reset busy", busy, 64'd0);
        check("reset valid", pv, 64'd0);
        check("reset vectors", {horz, vert} != 128'd0, 64'd0);
        check("reset addr", addr, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            paint(tbl[i]);
            e.h   = tbl[i].exp_h;
            e.v   = tbl[i].exp_v;
            e.cyc = DONE_CYC;
            run_scan(e, -1, $sformatf("vec%0d", i));
        end

        // Reset at cycle 3000 aborts the scan with no valid pulse.
        paint(tbl[5]);
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("abort addr", addr, 64'd0);
        check("abort horz", horz, 64'd0);
        check("abort vert", vert, 64'd0);
        check("abort busy/valid", {busy, pv}, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        pv_seen = 0;
        repeat (DONE_CYC + 200) begin
            @(negedge clk);
            if (pv) pv_seen++;
        end
        check("abort no valid", pv_seen, 64'd0);
        check("abort idle", busy, 64'd0);

        // Fresh scan with an ignored start pulse in the middle.
        e.h   = tbl[5].exp_h;
        e.v   = tbl[5].exp_v;
        e.cyc = DONE_CYC;
        run_scan(e, 4000, "restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
